// File: rtl/imem_arb.sv
//------------------------------------------------------------------------------
// imem_arb
//   Two-requester arbiter in front of a combinational instruction ROM.
//   Fetch has default priority. A debug/loader requester that keeps losing
//   builds up a starve count; once it reaches STARVE_MAX the arbiter switches
//   to FORCE and gives the next cycle to debug. Read data is registered, so
//   each grant yields its result one cycle later.
//
//   Optional feature macro: IMEM_ARB_DEBUG_EN
//     defined   : debug port, starve counter and NORMAL/FORCE FSM are built.
//     undefined : fetch-only; d_gnt and d_rvalid tie to 0, d_req and d_addr
//                 are ignored, mem_addr follows f_addr.
//
//   Ports
//     clk       in   system clock, rising edge
//     reset     in   asynchronous active-low reset
//     f_req     in   fetch read request
//     f_addr    in   fetch word address [5:0]
//     f_gnt     out  fetch granted this cycle (combinational)
//     f_rvalid  out  rdata holds a fetch result
//     d_req     in   debug read request
//     d_addr    in   debug word address [5:0]
//     d_gnt     out  debug granted this cycle (combinational)
//     d_rvalid  out  rdata holds a debug result
//     mem_addr  out  ROM address [5:0]
//     mem_q     in   ROM read data [N-1:0]
//     rdata     out  registered read data [N-1:0]
//
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imem_arb #(
  parameter int N          = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         f_req,
  input  logic [5:0]   f_addr,
  output logic         f_gnt,
  output logic         f_rvalid,
  input  logic         d_req,
  input  logic [5:0]   d_addr,
  output logic         d_gnt,
  output logic         d_rvalid,
  output logic [5:0]   mem_addr,
  input  logic [N-1:0] mem_q,
  output logic [N-1:0] rdata
);

`ifdef IMEM_ARB_DEBUG_EN

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic [3:0] cnt_inc;
  logic       force_dbg;

  always_comb begin
    cnt_inc   = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
    // FORCE is only entered once the count has reached STARVE_MAX, so
    // being in FORCE with a live request is the starvation condition.
    force_dbg = (state == FORCE) && d_req;
    // Grants are gated by reset so nothing is granted while held in reset.
    d_gnt     = reset && d_req && (force_dbg || !f_req);
    f_gnt     = reset && f_req && !d_gnt;
    mem_addr  = d_gnt ? d_addr : f_addr;
  end

  // Arbitration FSM and starve counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NORMAL;
      starve_cnt <= 4'd0;
    end else begin
      if (d_req && !d_gnt) begin
        starve_cnt <= cnt_inc;
        if (cnt_inc >= 4'(STARVE_MAX)) begin
          state <= FORCE;
        end
      end else begin
        // Either debug was served or it withdrew: starvation is over.
        starve_cnt <= 4'd0;
        state      <= NORMAL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_rvalid <= 1'b0;
    end else begin
      d_rvalid <= d_gnt;
    end
  end

`else

  // Fetch-only build: debug inputs and the starve limit have no effect.
  logic unused_dbg;
  assign unused_dbg = ^{d_req, d_addr, 4'(STARVE_MAX)};

  assign d_gnt    = 1'b0;
  assign d_rvalid = 1'b0;
  assign f_gnt    = reset && f_req;
  assign mem_addr = f_addr;

`endif

  // Shared read path: capture ROM data on any grant; hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_rvalid <= 1'b0;
      rdata    <= '0;
    end else begin
      f_rvalid <= f_gnt;
      if (f_gnt || d_gnt) begin
        rdata <= mem_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_arb.sv
`default_nettype none

module tb_imem_arb;

  localparam int N  = 32;
  localparam int SM = 4;
`ifdef IMEM_ARB_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         f_req;
  logic [5:0]   f_addr;
  logic         f_gnt;
  logic         f_rvalid;
  logic         d_req;
  logic [5:0]   d_addr;
  logic         d_gnt;
  logic         d_rvalid;
  logic [5:0]   mem_addr;
  logic [N-1:0] mem_q;
  logic [N-1:0] rdata;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           m_cnt;
  logic [N-1:0] m_rdata;
  logic         m_fv;
  logic         m_dv;
  logic         obs_f;
  logic         obs_d;

  imem_arb #(.N(N), .STARVE_MAX(SM)) dut (
    .clk      (clk),
    .reset    (reset),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .mem_addr (mem_addr),
    .mem_q    (mem_q),
    .rdata    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [5:0] a);
    case (a)
      6'd0:    rom = 32'hf8000001;
      6'd1:    rom = 32'hf8008002;
      6'd3:    rom = 32'h8b050083;
      6'd46:   rom = 32'hb400001f;
      default: rom = {2'b10, a, 6'h00, ~a, 12'h5a5};
    endcase
  endfunction

  always_comb mem_q = rom(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_rdata = '0;
    m_fv    = 1'b0;
    m_dv    = 1'b0;
  endtask

  // One clock cycle: drive, check grants mid-cycle, check results after edge.
  task automatic cycle(input logic fr, input logic [5:0] fa, input logic dr, input logic [5:0] da);
    logic       eg_f;
    logic       eg_d;
    logic [5:0] ea;
    f_req  = fr;
    f_addr = fa;
    d_req  = dr;
    d_addr = da;
    @(negedge clk);
    eg_d = DBG && reset && dr && (!fr || m_cnt >= SM);
    eg_f = reset && fr && !eg_d;
    ea   = eg_d ? da : fa;
    obs_f = f_gnt;
    obs_d = d_gnt;
    chk("f_gnt", 64'(f_gnt), 64'(eg_f));
    chk("d_gnt", 64'(d_gnt), 64'(eg_d));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    @(posedge clk);
    #1;
    if (eg_f || eg_d) m_rdata = rom(ea);
    m_fv = eg_f;
    m_dv = eg_d;
    if (DBG && dr && !eg_d) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    else m_cnt = 0;
    chk("f_rvalid", 64'(f_rvalid), 64'(m_fv));
    chk("d_rvalid", 64'(d_rvalid), 64'(m_dv));
    chk("rdata", 64'(rdata), 64'(m_rdata));
  endtask

  initial begin
    int first_dgnt;
    reset  = 1'b0;
    f_req  = 1'b1;
    f_addr = 6'd0;
    d_req  = 1'b0;
    d_addr = 6'd0;
    model_reset();

    // Reset: request held high, nothing may be granted or returned.
    @(posedge clk);
    @(negedge clk);
    chk("rst_f_gnt", 64'(f_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_f_rvalid", 64'(f_rvalid), 64'd0);
    chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rel_f_gnt", 64'(f_gnt), 64'd1);

    // Fetch only, back to back.
    cycle(1'b1, 6'd0, 1'b0, 6'd0);
    chk("fetch_a0", 64'(rdata), 64'h00000000f8000001);
    chk("fetch_a0_v", 64'(f_rvalid), 64'd1);
    cycle(1'b1, 6'd1, 1'b0, 6'd0);
    chk("fetch_a1", 64'(rdata), 64'h00000000f8008002);
    chk("fetch_a1_v", 64'(f_rvalid), 64'd1);
    cycle(1'b1, 6'd63, 1'b0, 6'd0);
    chk("fetch_a63", 64'(rdata), 64'(rom(6'd63)));
    // Idle cycle holds rdata and drops rvalid.
    cycle(1'b0, 6'd5, 1'b0, 6'd0);
    chk("idle_hold", 64'(rdata), 64'(rom(6'd63)));

`ifdef IMEM_ARB_DEBUG_EN
    // Contention: debug wins only on the fifth cycle.
    first_dgnt = 0;
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b1, 6'(i + 8), 1'b1, 6'd3);
      if (obs_d && first_dgnt == 0) first_dgnt = i;
      if (i == 5) begin
        chk("cont_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("cont_rdata", 64'(rdata), 64'h000000008b050083);
      end
      if (i == 6) chk("cont_fetch_resume", 64'(obs_f), 64'd1);
    end
    chk("cont_first_dgnt", 64'(first_dgnt), 64'd5);
    // Debug alone is granted immediately.
    cycle(1'b0, 6'd0, 1'b1, 6'd46);
    chk("dbg_alone_gnt", 64'(obs_d), 64'd1);
    chk("dbg_alone_rdata", 64'(rdata), 64'h00000000b400001f);
    chk("dbg_alone_v", 64'(d_rvalid), 64'd1);
`else
    // Debug port compiled out: never granted, never valid.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 6'd0, 1'b1, 6'd5);
      chk("off_d_gnt", 64'(obs_d), 64'd0);
      chk("off_d_rvalid", 64'(d_rvalid), 64'd0);
    end
    first_dgnt = 0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end

    // Mid-operation reset: a valid result is pending and a new grant is live.
    cycle(1'b1, 6'd7, 1'b0, 6'd0);
    f_req  = 1'b1;
    f_addr = 6'd9;
    d_req  = 1'b1;
    d_addr = 6'd11;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_f_rvalid", 64'(f_rvalid), 64'd0);
    chk("mid_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("mid_rdata", 64'(rdata), 64'd0);
    chk("mid_f_gnt", 64'(f_gnt), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_edge_f_rvalid", 64'(f_rvalid), 64'd0);
    chk("mid_edge_rdata", 64'(rdata), 64'd0);
    reset = 1'b1;
    model_reset();
    cycle(1'b0, 6'd0, 1'b0, 6'd0);
    cycle(1'b1, 6'd2, 1'b0, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
